xif_bitops_coproc: RTL and testbench

- Parametrised successor to the single-instruction bit-counting coprocessor on the core's CV-X-IF.
- Accepts several custom bit-manipulation instructions: CNTB, CNTZ, FFS and PARITY.
- Holds up to QUEUE_DEPTH offloaded instructions awaiting commit. Honours commit/kill and executes committed instructions in order on a serial bit engine.
- Returns results over the result handshake. Sits beside the core, flattened X-IF signals only; no memory interface.

---
 rtl/xif_bitops_coproc_pkg.sv | 34 +++
 rtl/xif_bitops_coproc_if.sv | 40 ++++
 rtl/xif_bitops_coproc_engine.sv | 98 +++++++++
 rtl/xif_bitops_coproc.sv | 176 +++++++++++++++++
 tb/tb_xif_bitops_coproc.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xif_bitops_coproc_pkg.sv
// Shared definitions for the bit-manipulation coprocessor: opcode, funct3
// encodings, operation enum, engine state enum and the queue entry layout.
package custom_instr_pkg;

  localparam logic [6:0] OPCODE_BITOPS = 7'b0001011;

  localparam logic [2:0] FUNCT3_CNTB   = 3'b000;
  localparam logic [2:0] FUNCT3_CNTZ   = 3'b001;
  localparam logic [2:0] FUNCT3_FFS    = 3'b010;
  localparam logic [2:0] FUNCT3_PARITY = 3'b011;

  typedef enum logic [1:0] {
    OP_CNTB   = 2'd0,
    OP_CNTZ   = 2'd1,
    OP_FFS    = 2'd2,
    OP_PARITY = 2'd3
  } bitop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } eng_state_e;

  // Width-independent part of a queue entry; id and operands are kept in
  // parallel arrays in the top so the widths can follow its parameters.
  typedef struct packed {
    bitop_e     op;
    logic [4:0] rd;
    logic       committed;
    logic       killed;
  } bitop_entry_t;

endpackage

// File: rtl/xif_bitops_coproc_if.sv
// Flattened X-IF issue/commit/result signals between core and coprocessor.
interface xif_bitops_coproc_if #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4
);
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic [XLEN-1:0]     issue_rs0_i;
  logic [XLEN-1:0]     issue_rs1_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [XLEN-1:0]     result_data_o;
  logic [4:0]          result_rd_o;
  logic                result_we_o;
  logic                busy_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    output busy_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs0_i, issue_rs1_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    input  busy_o
  );
endinterface

// File: rtl/xif_bitops_coproc_engine.sv
// Serial bit engine: consumes BITS_PER_CYCLE operand bits per cycle from the
// LSB. o_done is high in the last busy cycle, with o_result already final.
module bitop_engine
  import custom_instr_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_start,
  input  bitop_e          i_op,
  input  logic [XLEN-1:0] i_rs0,
  input  logic [XLEN-1:0] i_rs1,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [XLEN-1:0]           r_a, r_b, r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_busy, r_found;
  bitop_e                    r_op;
  logic [BITS_PER_CYCLE-1:0] w_and, w_andn;
  logic [XLEN-1:0]           w_pc_and, w_pc_andn, w_low, w_acc_nxt;
  logic                      w_hit, w_found_nxt;

  // Per-chunk popcounts, lowest-set-bit search and next accumulator value.
  always_comb begin
    w_and     = r_a[BITS_PER_CYCLE-1:0] & r_b[BITS_PER_CYCLE-1:0];
    w_andn    = ~r_a[BITS_PER_CYCLE-1:0] & r_b[BITS_PER_CYCLE-1:0];
    w_pc_and  = '0;
    w_pc_andn = '0;
    w_low     = '0;
    w_hit     = 1'b0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      w_pc_and  = w_pc_and + XLEN'(w_and[j]);
      w_pc_andn = w_pc_andn + XLEN'(w_andn[j]);
    end
    for (int j = BITS_PER_CYCLE - 1; j >= 0; j--) begin
      if (r_a[j]) begin
        w_hit = 1'b1;
        w_low = XLEN'(j);
      end else begin
        w_hit = w_hit;
      end
    end
    w_acc_nxt   = r_acc;
    w_found_nxt = r_found;
    case (r_op)
      OP_CNTB:   w_acc_nxt = r_acc + w_pc_and;
      OP_CNTZ:   w_acc_nxt = r_acc + w_pc_andn;
      OP_PARITY: w_acc_nxt = {r_acc[XLEN-1:1], r_acc[0] ^ (^w_and)};
      OP_FFS: begin
        if (!r_found && w_hit) begin
          w_acc_nxt   = XLEN'(r_idx) * XLEN'(BITS_PER_CYCLE) + w_low;
          w_found_nxt = 1'b1;
        end else begin
          w_acc_nxt   = r_acc;
        end
      end
      default:   w_acc_nxt = r_acc;
    endcase
  end

  assign o_done   = r_busy && (r_idx == IDX_W'(N - 1));
  assign o_result = w_acc_nxt;

  // Operand load on start, then one chunk per cycle until the last one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_found <= 1'b0;
      r_op    <= OP_CNTB;
    end else if (i_start) begin
      r_a     <= i_rs0;
      r_b     <= i_rs1;
      // FFS starts at XLEN so an all-zero operand needs no special case.
      r_acc   <= (i_op == OP_FFS) ? XLEN'(XLEN) : '0;
      r_idx   <= '0;
      r_busy  <= 1'b1;
      r_found <= 1'b0;
      r_op    <= i_op;
    end else if (r_busy) begin
      r_a     <= r_a >> BITS_PER_CYCLE;
      r_b     <= r_b >> BITS_PER_CYCLE;
      r_acc   <= w_acc_nxt;
      r_found <= w_found_nxt;
      r_idx   <= r_idx + IDX_W'(1);
      r_busy  <= !o_done;
    end
  end
endmodule

// File: rtl/xif_bitops_coproc.sv
// Bit-manipulation coprocessor on CV-X-IF: decodes and queues offloaded
// instructions, applies commit/kill, executes in order on bitop_engine.
module xif_bitops_coproc
  import custom_instr_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ID_WIDTH       = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  xif_bitops_coproc_if.slave  xif
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bitop_entry_t          r_q   [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]   r_id  [QUEUE_DEPTH];
  logic [XLEN-1:0]       r_rs0 [QUEUE_DEPTH];
  logic [XLEN-1:0]       r_rs1 [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]      r_head, r_tail;
  logic [CNT_W-1:0]      r_count;
  eng_state_e            r_state;
  logic                  r_res_valid, r_res_we;
  logic [ID_WIDTH-1:0]   r_res_id;
  logic [XLEN-1:0]       r_res_data;
  logic [4:0]            r_res_rd;

  logic                  w_ready, w_known, w_accept, w_enq, w_pop, w_start;
  logic                  w_head_valid, w_head_commit, w_head_kill, w_eng_done;
  bitop_e                w_op;
  logic [QUEUE_DEPTH-1:0] w_match;
  logic [XLEN-1:0]       w_eng_result;
  logic                  w_unused;

  assign w_unused = ^xif.issue_instr_i[31:15];
  assign w_ready  = (r_count < CNT_W'(QUEUE_DEPTH));

  // Instruction decode: opcode check and funct3 to operation mapping.
  always_comb begin
    w_known = 1'b1;
    w_op    = OP_CNTB;
    case (xif.issue_instr_i[14:12])
      FUNCT3_CNTB:   w_op = OP_CNTB;
      FUNCT3_CNTZ:   w_op = OP_CNTZ;
      FUNCT3_FFS:    w_op = OP_FFS;
      FUNCT3_PARITY: w_op = OP_PARITY;
      default:       w_known = 1'b0;
    endcase
    w_accept = w_known && (xif.issue_instr_i[6:0] == OPCODE_BITOPS);
  end

  assign xif.issue_ready_o     = w_ready;
  assign xif.issue_accept_o    = xif.issue_valid_i && w_ready && w_accept;
  assign xif.issue_writeback_o = xif.issue_accept_o && (xif.issue_instr_i[11:7] != 5'd0);
  assign w_enq = xif.issue_accept_o;

  // Commit matching, with a same-cycle bypass onto the head so a commit
  // starts the engine without waiting for the flag to be stored.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_match[i] = xif.commit_valid_i && r_valid[i] && !r_q[i].committed &&
                   !r_q[i].killed && (r_id[i] == xif.commit_id_i);
    end
    w_head_valid  = r_valid[r_head];
    w_head_kill   = w_head_valid &&
                    (r_q[r_head].killed || (w_match[r_head] && xif.commit_kill_i));
    w_head_commit = w_head_valid && !w_head_kill &&
                    (r_q[r_head].committed || (w_match[r_head] && !xif.commit_kill_i));
    w_start = (r_state == ST_IDLE) && w_head_commit;
    w_pop   = ((r_state == ST_IDLE) && w_head_kill) ||
              ((r_state == ST_RESULT) && xif.result_ready_i);
  end

  // Queue storage: commit/kill marking, head pop and tail enqueue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q[i]   <= '0;
        r_id[i]  <= '0;
        r_rs0[i] <= '0;
        r_rs1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (w_match[i]) begin
          if (xif.commit_kill_i) r_q[i].killed <= 1'b1;
          else                   r_q[i].committed <= 1'b1;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_q[r_tail]     <= '{op: w_op, rd: xif.issue_instr_i[11:7],
                             committed: 1'b0, killed: 1'b0};
        r_id[r_tail]    <= xif.issue_id_i;
        r_rs0[r_tail]   <= xif.issue_rs0_i;
        r_rs1[r_tail]   <= xif.issue_rs1_i;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  bitop_engine #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_engine (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_start  (w_start),
    .i_op     (r_q[r_head].op),
    .i_rs0    (r_rs0[r_head]),
    .i_rs1    (r_rs1[r_head]),
    .o_done   (w_eng_done),
    .o_result (w_eng_result)
  );

  // Execution FSM with registered result outputs held until the handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_res_valid <= 1'b0;
      r_res_we    <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_rd    <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_eng_done) begin
            r_state     <= ST_RESULT;
            r_res_valid <= 1'b1;
            r_res_data  <= w_eng_result;
            r_res_id    <= r_id[r_head];
            r_res_rd    <= r_q[r_head].rd;
            r_res_we    <= (r_q[r_head].rd != 5'd0);
          end
        end
        ST_RESULT: begin
          if (xif.result_ready_i) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign xif.result_valid_o = r_res_valid;
  assign xif.result_data_o  = r_res_data;
  assign xif.result_id_o    = r_res_id;
  assign xif.result_rd_o    = r_res_rd;
  assign xif.result_we_o    = r_res_we;
  assign xif.busy_o         = (r_count != CNT_W'(0)) || (r_state != ST_IDLE);
endmodule

// File: tb/tb_xif_bitops_coproc.sv
// Directed self-checking bench for xif_bitops_coproc.
module tb_xif_bitops_coproc;
  localparam logic [6:0] OPC = 7'b0001011;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  xif_bitops_coproc_if #(.XLEN(32), .ID_WIDTH(4)) xif ();

  xif_bitops_coproc #(
    .XLEN(32), .ID_WIDTH(4), .QUEUE_DEPTH(4), .BITS_PER_CYCLE(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .xif   (xif)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, OPC};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [31:0] instr, input logic [3:0] id,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic acc, output logic wb);
    xif.issue_valid_i = 1'b1;
    xif.issue_instr_i = instr;
    xif.issue_id_i    = id;
    xif.issue_rs0_i   = a;
    xif.issue_rs1_i   = b;
    #1;
    for (int k = 0; k < 20 && !xif.issue_ready_o; k++) tick();
    acc = xif.issue_accept_o;
    wb  = xif.issue_writeback_o;
    tick();
    xif.issue_valid_i = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
    tick();
    xif.commit_valid_i = 1'b0;
    xif.commit_kill_i  = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (xif.result_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic take();
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic wb, output logic ok,
                         output logic [31:0] data, output logic we);
    logic acc;
    do_issue(instr, id, a, b, acc, wb);
    do_commit(id, 1'b0);
    wait_valid(ok);
    data = xif.result_data_o;
    we   = xif.result_we_o;
    take();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    xif.issue_valid_i = 1'b0; xif.issue_instr_i = 32'd0; xif.issue_id_i = 4'd0;
    xif.issue_rs0_i = 32'd0; xif.issue_rs1_i = 32'd0;
    xif.commit_valid_i = 1'b0; xif.commit_id_i = 4'd0; xif.commit_kill_i = 1'b0;
    xif.result_ready_i = 1'b0;
    tick(); tick();
    total++;
    if ({xif.issue_ready_o, xif.result_valid_o, xif.result_we_o, xif.busy_o} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000",
        {xif.issue_ready_o, xif.result_valid_o, xif.result_we_o, xif.busy_o});
    end
    total++;
    if ({xif.result_data_o, xif.result_id_o, xif.result_rd_o} !== 41'd0) begin
      bad++; $display("FAIL reset_fields got=%0h exp=0",
        {xif.result_data_o, xif.result_id_o, xif.result_rd_o});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cntb();
    logic acc, wb;
    do_issue(mk(3'b000, 5'd5), 4'd3, 32'hF0F0_00FF, 32'hFFFF_FFFF, acc, wb);
    total++;
    if ({acc, wb} !== 2'b11) begin
      bad++; $display("FAIL cntb_accept got=%b exp=11", {acc, wb});
    end
    do_commit(4'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (xif.result_valid_o !== 1'b0) begin
        bad++; $display("FAIL cntb_early_valid cycle=%0d got=%b exp=0", k, xif.result_valid_o);
      end
    end
    tick();
    total++;
    if (xif.result_valid_o !== 1'b1) begin
      bad++; $display("FAIL cntb_latency got=%b exp=1", xif.result_valid_o);
    end
    total++;
    if ({xif.result_data_o, xif.result_rd_o, xif.result_we_o, xif.result_id_o} !==
        {32'd16, 5'd5, 1'b1, 4'd3}) begin
      bad++; $display("FAIL cntb_result data=%0d rd=%0d we=%b id=%0d exp 16/5/1/3",
        xif.result_data_o, xif.result_rd_o, xif.result_we_o, xif.result_id_o);
    end
    take();
    total++;
    if ({xif.result_valid_o, xif.busy_o} !== 2'b00) begin
      bad++; $display("FAIL cntb_after got=%b exp=00", {xif.result_valid_o, xif.busy_o});
    end
  endtask

  task automatic test_reject();
    logic acc, wb;
    do_issue(mk(3'b111, 5'd4), 4'd7, 32'h1, 32'h1, acc, wb);
    total++;
    if ({acc, wb} !== 2'b00) begin
      bad++; $display("FAIL reject_accept got=%b exp=00", {acc, wb});
    end
    total++;
    if (xif.busy_o !== 1'b0) begin
      bad++; $display("FAIL reject_busy got=%b exp=0", xif.busy_o);
    end
    do_commit(4'd7, 1'b0);
    repeat (6) tick();
    total++;
    if ({xif.result_valid_o, xif.busy_o} !== 2'b00) begin
      bad++; $display("FAIL reject_commit got=%b exp=00", {xif.result_valid_o, xif.busy_o});
    end
  endtask

  task automatic test_fill();
    logic acc, wb, ok;
    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    logic [31:0] e_v [4];
    a_v = '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_000F, 32'hFFFF_FFFF};
    b_v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
    e_v = '{32'd32, 32'd16, 32'd4, 32'd0};
    for (int i = 0; i < 4; i++) begin
      do_issue(mk(3'b001, 5'(i + 1)), 4'(8 + i), a_v[i], b_v[i], acc, wb);
      total++;
      if (acc !== 1'b1) begin
        bad++; $display("FAIL fill_accept idx=%0d got=%b exp=1", i, acc);
      end
    end
    total++;
    if (xif.issue_ready_o !== 1'b0) begin
      bad++; $display("FAIL fill_full_ready got=%b exp=0", xif.issue_ready_o);
    end
    xif.issue_valid_i = 1'b1; xif.issue_instr_i = mk(3'b000, 5'd1); xif.issue_id_i = 4'd12;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b00) begin
        bad++; $display("FAIL fill_stall cycle=%0d got=%b exp=00", k,
          {xif.issue_ready_o, xif.issue_accept_o});
      end
    end
    xif.issue_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) do_commit(4'(8 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL fill_timeout idx=%0d got=0 exp=1", i);
      end
      total++;
      if ({xif.result_id_o, xif.result_data_o} !== {4'(8 + i), e_v[i]}) begin
        bad++; $display("FAIL fill_order idx=%0d id=%0d data=%0d exp id=%0d data=%0d",
          i, xif.result_id_o, xif.result_data_o, 8 + i, e_v[i]);
      end
      if (i == 0) begin
        total++;
        if (xif.issue_ready_o !== 1'b0) begin
          bad++; $display("FAIL fill_ready_before_pop got=%b exp=0", xif.issue_ready_o);
        end
      end
      take();
      if (i == 0) begin
        total++;
        if (xif.issue_ready_o !== 1'b1) begin
          bad++; $display("FAIL fill_ready_after_pop got=%b exp=1", xif.issue_ready_o);
        end
      end
    end
  endtask

  task automatic test_kill();
    logic acc, wb, ok;
    do_issue(mk(3'b000, 5'd6), 4'd1, 32'h0000_00FF, 32'h0000_00FF, acc, wb);
    do_issue(mk(3'b011, 5'd7), 4'd2, 32'h0000_0007, 32'h0000_0001, acc, wb);
    do_commit(4'd1, 1'b1);
    do_commit(4'd2, 1'b0);
    wait_valid(ok);
    total++;
    if (!ok || {xif.result_id_o, xif.result_data_o, xif.result_rd_o} !== {4'd2, 32'd1, 5'd7}) begin
      bad++; $display("FAIL kill_result ok=%b id=%0d data=%0d rd=%0d exp id=2 data=1 rd=7",
        ok, xif.result_id_o, xif.result_data_o, xif.result_rd_o);
    end
    take();
    repeat (6) tick();
    total++;
    if ({xif.result_valid_o, xif.busy_o} !== 2'b00) begin
      bad++; $display("FAIL kill_extra got=%b exp=00", {xif.result_valid_o, xif.busy_o});
    end
  endtask

  task automatic test_ops();
    logic wb, ok, we;
    logic [31:0] data;
    run_one(mk(3'b010, 5'd3), 4'd4, 32'h0000_0000, 32'h0, wb, ok, data, we);
    total++;
    if (!ok || data !== 32'd32) begin
      bad++; $display("FAIL ffs_zero ok=%b got=%0d exp=32", ok, data);
    end
    run_one(mk(3'b010, 5'd3), 4'd5, 32'h0000_8000, 32'h0, wb, ok, data, we);
    total++;
    if (!ok || data !== 32'd15) begin
      bad++; $display("FAIL ffs_bit15 ok=%b got=%0d exp=15", ok, data);
    end
    run_one(mk(3'b011, 5'd0), 4'd6, 32'h0000_0007, 32'h0000_0005, wb, ok, data, we);
    total++;
    if (!ok || {data, we, wb} !== {32'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL parity_rd0 ok=%b data=%0d we=%b wb=%b exp 0/0/0", ok, data, we, wb);
    end
  endtask

  task automatic test_hold();
    logic acc, wb, ok;
    do_issue(mk(3'b000, 5'd9), 4'd5, 32'hFFFF_FFFF, 32'h0000_FFFF, acc, wb);
    do_commit(4'd5, 1'b0);
    wait_valid(ok);
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({xif.result_valid_o, xif.result_data_o, xif.result_id_o, xif.result_rd_o, xif.result_we_o}
          !== {1'b1, 32'd16, 4'd5, 5'd9, 1'b1}) begin
        bad++; $display("FAIL hold cycle=%0d v=%b data=%0d id=%0d rd=%0d exp 1/16/5/9", k,
          xif.result_valid_o, xif.result_data_o, xif.result_id_o, xif.result_rd_o);
      end
      tick();
    end
    take();
  endtask

  task automatic test_reset_mid();
    logic acc, wb;
    do_issue(mk(3'b000, 5'd2), 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, wb);
    do_commit(4'd9, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({xif.issue_ready_o, xif.result_valid_o, xif.busy_o, xif.result_data_o, xif.result_we_o}
        !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0}) begin
      bad++; $display("FAIL reset_mid ready=%b valid=%b busy=%b data=%0h exp 1/0/0/0",
        xif.issue_ready_o, xif.result_valid_o, xif.busy_o, xif.result_data_o);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if ({xif.result_valid_o, xif.busy_o} !== 2'b00) begin
        bad++; $display("FAIL reset_mid_empty cycle=%0d got=%b exp=00", k,
          {xif.result_valid_o, xif.busy_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_cntb();
    test_reject();
    test_fill();
    test_kill();
    test_ops();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
